// File: rtl/sdram_init_pkg.sv
// Shared types for the SDRAM power-up sequencer: command encodings, FSM states and
// the precharge-all address bit.
package sdram_init_pkg;

    // {cs_n, ras_n, cas_n, we_n}
    typedef enum logic [3:0] {
        SDR_CMD_NOP = 4'b1111,
        SDR_CMD_PRE = 4'b0010,
        SDR_CMD_REF = 4'b0001,
        SDR_CMD_LMR = 4'b0000
    } sdr_cmd_e;

    typedef enum logic [2:0] {
        ST_PWRUP = 3'd0,
        ST_PRE   = 3'd1,
        ST_TRP   = 3'd2,
        ST_REF   = 3'd3,
        ST_TRFC  = 3'd4,
        ST_LMR   = 3'd5,
        ST_TMRD  = 3'd6,
        ST_DONE  = 3'd7
    } init_state_e;

    localparam int A10_BIT = 10;

    function automatic int max4(input int a, input int b, input int c, input int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

endpackage

// File: rtl/sdram_init_sequencer_if.sv
// Command-pin bundle between the init sequencer (master) and the pad ring / controller side (slave).
// init_req only exists when SDR_INIT_REINIT_EN is defined.
interface sdram_init_sequencer_if #(
    parameter int SDR_AW = 13,
    parameter int SDR_BW = 2
);
    logic [SDR_AW-1:0] cfg_mode_reg;
`ifdef SDR_INIT_REINIT_EN
    logic              init_req;
`endif
    logic              sdr_cs_n;
    logic              sdr_ras_n;
    logic              sdr_cas_n;
    logic              sdr_we_n;
    logic [SDR_AW-1:0] sdr_addr;
    logic [SDR_BW-1:0] sdr_ba;
    logic              sdr_init_done;

`ifdef SDR_INIT_REINIT_EN
    modport master (
        input  cfg_mode_reg, init_req,
        output sdr_cs_n, sdr_ras_n, sdr_cas_n, sdr_we_n, sdr_addr, sdr_ba, sdr_init_done
    );
    modport slave (
        output cfg_mode_reg, init_req,
        input  sdr_cs_n, sdr_ras_n, sdr_cas_n, sdr_we_n, sdr_addr, sdr_ba, sdr_init_done
    );
`else
    modport master (
        input  cfg_mode_reg,
        output sdr_cs_n, sdr_ras_n, sdr_cas_n, sdr_we_n, sdr_addr, sdr_ba, sdr_init_done
    );
    modport slave (
        output cfg_mode_reg,
        input  sdr_cs_n, sdr_ras_n, sdr_cas_n, sdr_we_n, sdr_addr, sdr_ba, sdr_init_done
    );
`endif

endinterface

// File: rtl/sdram_init_wait_cnt.sv
// Loadable down-counter used for every init wait; holds at zero instead of wrapping.
module sdram_init_wait_cnt #(
    parameter int WIDTH = 9
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_val_i,
    output logic             zero_o
);

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;

    // Next count: load wins, otherwise count down and stick at zero.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - WIDTH'(1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Counter register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/sdram_init_sequencer.sv
// SDRAM power-up sequencer: NOP wait, PRECHARGE ALL, REF_CNT x AUTO REFRESH, LMR, then init_done.
// Define SDR_INIT_REINIT_EN to add init_req, which restarts the sequence from PRECHARGE while in DONE.
module sdram_init_sequencer
    import sdram_init_pkg::*;
#(
    parameter int T_PWRUP = 505,
    parameter int T_RP    = 3,
    parameter int T_RFC   = 7,
    parameter int REF_CNT = 2,
    parameter int T_MRD   = 8,
    parameter int SDR_AW  = 13,
    parameter int SDR_BW  = 2
) (
    input  logic                   sdram_clk,
    input  logic                   reset,
    sdram_init_sequencer_if.master bus
);

    localparam int CNT_W = $clog2(max4(T_PWRUP, T_RP, T_RFC, T_MRD) + 1);
    localparam int REF_W = $clog2(REF_CNT + 1);
    localparam logic [SDR_AW-1:0] PRE_ADDR = SDR_AW'(1) << A10_BIT;

    init_state_e       state_q, state_d;
    logic              armed_q, armed_d;
    logic [REF_W-1:0]  ref_q, ref_d;
    logic              cnt_load_s;
    logic [CNT_W-1:0]  cnt_val_s;
    logic              cnt_zero_s;
    logic              reinit_req_s;

    sdr_cmd_e          cmd_q, cmd_d;
    logic [SDR_AW-1:0] addr_q, addr_d;
    logic [SDR_BW-1:0] ba_q, ba_d;
    logic              done_q, done_d;

`ifdef SDR_INIT_REINIT_EN
    assign reinit_req_s = bus.init_req;
`else
    assign reinit_req_s = 1'b0;
`endif

    sdram_init_wait_cnt #(
        .WIDTH (CNT_W)
    ) u_wait_cnt (
        .clk_i      (sdram_clk),
        .rst_i      (reset),
        .load_i     (cnt_load_s),
        .load_val_i (cnt_val_s),
        .zero_o     (cnt_zero_s)
    );

    // State, bookkeeping and output registers.
    always_ff @(posedge sdram_clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_PWRUP;
            armed_q <= 1'b0;
            ref_q   <= '0;
            cmd_q   <= SDR_CMD_NOP;
            addr_q  <= '0;
            ba_q    <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            armed_q <= armed_d;
            ref_q   <= ref_d;
            cmd_q   <= cmd_d;
            addr_q  <= addr_d;
            ba_q    <= ba_d;
            done_q  <= done_d;
        end
    end

    // Next state and wait-counter loading; command states always last exactly one cycle.
    always_comb begin
        state_d    = state_q;
        armed_d    = armed_q;
        ref_d      = ref_q;
        cnt_load_s = 1'b0;
        cnt_val_s  = '0;
        case (state_q)
            ST_PWRUP: begin
                armed_d = 1'b1;
                state_d = (armed_q && cnt_zero_s) ? ST_PRE : ST_PWRUP;
            end
            ST_PRE: begin
                ref_d   = REF_W'(REF_CNT);
                state_d = cnt_zero_s ? ST_REF : ST_TRP;
            end
            ST_TRP: begin
                state_d = cnt_zero_s ? ST_REF : ST_TRP;
            end
            // ref_q still counts the refresh being issued now
            ST_REF: begin
                ref_d = ref_q - REF_W'(1);
                if (cnt_zero_s) begin
                    state_d = (ref_q > REF_W'(1)) ? ST_REF : ST_LMR;
                end else begin
                    state_d = ST_TRFC;
                end
            end
            ST_TRFC: begin
                if (cnt_zero_s) begin
                    state_d = (ref_q != '0) ? ST_REF : ST_LMR;
                end else begin
                    state_d = ST_TRFC;
                end
            end
            ST_LMR: begin
                state_d = cnt_zero_s ? ST_DONE : ST_TMRD;
            end
            ST_TMRD: begin
                state_d = cnt_zero_s ? ST_DONE : ST_TMRD;
            end
            ST_DONE: begin
                state_d = reinit_req_s ? ST_PRE : ST_DONE;
            end
            default: begin
                state_d = ST_PWRUP;
            end
        endcase

        // The power-up wait is loaded on the first edge after reset, since reset leaves the counter at zero.
        if (state_q == ST_PWRUP && !armed_q) begin
            cnt_load_s = 1'b1;
            cnt_val_s  = CNT_W'(T_PWRUP - 1);
        end else begin
            case (state_d)
                ST_PRE: begin
                    cnt_load_s = 1'b1;
                    cnt_val_s  = CNT_W'(T_RP - 1);
                end
                ST_REF: begin
                    cnt_load_s = 1'b1;
                    cnt_val_s  = CNT_W'(T_RFC - 1);
                end
                ST_LMR: begin
                    cnt_load_s = 1'b1;
                    cnt_val_s  = CNT_W'(T_MRD - 1);
                end
                default: begin
                    cnt_load_s = 1'b0;
                    cnt_val_s  = '0;
                end
            endcase
        end
    end

    // Pin values for the upcoming state, registered on the same edge as the state.
    always_comb begin
        cmd_d  = SDR_CMD_NOP;
        addr_d = '0;
        ba_d   = '0;
        done_d = 1'b0;
        case (state_d)
            ST_PRE: begin
                cmd_d  = SDR_CMD_PRE;
                addr_d = PRE_ADDR;
            end
            ST_REF: begin
                cmd_d = SDR_CMD_REF;
            end
            ST_LMR: begin
                cmd_d  = SDR_CMD_LMR;
                addr_d = bus.cfg_mode_reg;
            end
            ST_DONE: begin
                done_d = 1'b1;
            end
            default: begin
                cmd_d = SDR_CMD_NOP;
            end
        endcase
    end

    assign {bus.sdr_cs_n, bus.sdr_ras_n, bus.sdr_cas_n, bus.sdr_we_n} = cmd_q;
    assign bus.sdr_addr      = addr_q;
    assign bus.sdr_ba        = ba_q;
    assign bus.sdr_init_done = done_q;

endmodule
